// File: rtl/bnn_conv_stream_if.sv
`default_nettype none
// ============================================================================
// Module : bnn_conv_stream_if - pixel-in / result-out stream bundle
// Rev    : 1.0 - initial release
// ============================================================================
interface bnn_conv_stream_if #(
  parameter int DW = 16,
  parameter int OW = 20
);
  logic signed [DW-1:0] din;
  logic                 din_valid;
  logic                 din_ready;
  logic signed [OW-1:0] dout;
  logic                 ovalid;
  logic                 done;
`ifdef BNN_CONV_BIN_OUT_EN
  logic                 bout;

  modport master (output din, din_valid, input din_ready, dout, ovalid, done, bout);
  modport slave  (input din, din_valid, output din_ready, dout, ovalid, done, bout);
`else
  modport master (output din, din_valid, input din_ready, dout, ovalid, done);
  modport slave  (input din, din_valid, output din_ready, dout, ovalid, done);
`endif
endinterface
`default_nettype wire

// File: rtl/bnn_conv_stream.sv
`default_nettype none
// ============================================================================
// Module : bnn_conv_stream - streaming binary-weight KxK convolution engine
//          (line buffer + window + +/-1 accumulate). Optional macro
//          BNN_CONV_BIN_OUT_EN adds the sign bit output bout.
// Rev    : 1.0 - initial release
// ============================================================================
module bnn_conv_stream #(
  parameter int DW    = 16,
  parameter int K     = 3,
  parameter int MAX_W = 32,
  parameter int DIM_W = 6
) (
  input  wire              clk,
  input  wire              rstn,
  input  wire              weight_en,
  input  wire              weight,
  input  wire              weight_clr,
  output logic             weight_full,
  input  wire [DIM_W-1:0]  img_w,
  input  wire [DIM_W-1:0]  img_h,
  input  wire              start,
  output logic             busy,
  bnn_conv_stream_if.slave st
);

  localparam int NW = K * K;
  localparam int OW = DW + $clog2(NW);
  localparam int CW = $clog2(NW + 1);
  localparam int AW = (MAX_W > 1) ? $clog2(MAX_W) : 1;
  localparam logic [DIM_W-1:0] K_D    = DIM_W'(K);
  localparam logic [DIM_W-1:0] KM1_D  = DIM_W'(K - 1);
  localparam logic [DIM_W-1:0] MAXW_D = DIM_W'(MAX_W);
  localparam logic [CW-1:0]    NW_C   = CW'(NW);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2
  } state_t;

  state_t state, state_nx;

  logic [CW-1:0]        wcnt;
  logic [NW-1:0]        wbits;
  logic [DIM_W-1:0]     fw, fh, row, col;
  logic [AW-1:0]        col_a;
  logic                 drain_cnt;
  logic                 din_rdy;
  logic                 go, accept, win_ok, last_px;
  logic                 win_vld, win_last;
  logic signed [DW-1:0] lb  [K-1][MAX_W];
  logic signed [DW-1:0] win [NW];
  logic signed [OW-1:0] acc, xe;
  logic signed [OW-1:0] dout_r;
  logic                 ovalid_r, done_r;

  assign weight_full = (wcnt == NW_C);
  assign go      = (state == IDLE) && start && weight_full &&
                   (img_w >= K_D) && (img_w <= MAXW_D) && (img_h >= K_D);
  assign accept  = st.din_valid && din_rdy;
  assign win_ok  = (row >= KM1_D) && (col >= KM1_D);
  assign last_px = (row == fh - 1'b1) && (col == fw - 1'b1);
  assign col_a   = col[AW-1:0];

  always_ff @(posedge clk) begin
    if (!rstn) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    din_rdy  = 1'b0;
    busy     = 1'b1;
    case (state)
      IDLE: begin
        busy = 1'b0;
        if (go) state_nx = RUN;
      end
      RUN: begin
        din_rdy = 1'b1;
        if (accept && last_px) state_nx = DRAIN;
      end
      DRAIN: begin
        if (drain_cnt) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

  // Weight bits are only writable while no frame is in flight.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      wcnt <= '0;
    end else if (state == IDLE) begin
      if (weight_clr)                     wcnt <= '0;
      else if (weight_en && !weight_full) wcnt <= wcnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (state == IDLE && !weight_clr && weight_en && !weight_full)
      wbits[wcnt] <= weight;
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      fw        <= '0;
      fh        <= '0;
      row       <= '0;
      col       <= '0;
      drain_cnt <= 1'b0;
      win_vld   <= 1'b0;
      win_last  <= 1'b0;
      ovalid_r  <= 1'b0;
      done_r    <= 1'b0;
      dout_r    <= '0;
    end else begin
      if (go) begin
        fw  <= img_w;
        fh  <= img_h;
        row <= '0;
        col <= '0;
      end else if (accept) begin
        if (col == fw - 1'b1) begin
          col <= '0;
          row <= row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
      drain_cnt <= (state == DRAIN) && !drain_cnt;
      win_vld   <= accept && win_ok;
      win_last  <= accept && last_px;
      ovalid_r  <= win_vld;
      done_r    <= win_vld && win_last;
      if (win_vld) dout_r <= acc;
    end
  end

  // Window row 0 / column 0 are the oldest; lb[j] holds the row j+1 above.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int r = 0; r < K; r++)
        for (int c = 0; c < K - 1; c++)
          win[r*K+c] <= win[r*K+c+1];
      for (int r = 0; r < K - 1; r++)
        win[r*K+K-1] <= lb[K-2-r][col_a];
      win[NW-1]    <= st.din;
      lb[0][col_a] <= st.din;
      for (int j = 1; j < K - 1; j++)
        lb[j][col_a] <= lb[j-1][col_a];
    end
  end

  always_comb begin
    acc = '0;
    xe  = '0;
    for (int i = 0; i < NW; i++) begin
      xe  = {{(OW-DW){win[i][DW-1]}}, win[i]};
      acc = wbits[i] ? (acc + xe) : (acc - xe);
    end
  end

  assign st.din_ready = din_rdy;
  assign st.dout      = dout_r;
  assign st.ovalid    = ovalid_r;
  assign st.done      = done_r;

`ifdef BNN_CONV_BIN_OUT_EN
  logic bout_r;

  always_ff @(posedge clk) begin
    if (!rstn)        bout_r <= 1'b0;
    else if (win_vld) bout_r <= ~acc[OW-1];
  end

  assign st.bout = bout_r;
`endif

endmodule
`default_nettype wire

// File: tb/tb_bnn_conv_stream.sv
`default_nettype none
// ============================================================================
// Module : tb_bnn_conv_stream - directed bench with a reference convolution model
// Rev    : 1.0 - initial release
// ============================================================================
module tb_bnn_conv_stream;
  localparam int DW = 16, K = 3, MAX_W = 32, DIM_W = 6;
  localparam int NW = K * K;
  localparam int OW = DW + $clog2(NW);

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic             weight_en = 1'b0, weight = 1'b0, weight_clr = 1'b0, start = 1'b0;
  logic [DIM_W-1:0] img_w = '0, img_h = '0;
  logic             weight_full, busy;

  bnn_conv_stream_if #(.DW(DW), .OW(OW)) st ();

  bnn_conv_stream #(.DW(DW), .K(K), .MAX_W(MAX_W), .DIM_W(DIM_W)) dut (
    .clk(clk), .rstn(rstn),
    .weight_en(weight_en), .weight(weight), .weight_clr(weight_clr),
    .weight_full(weight_full),
    .img_w(img_w), .img_h(img_h), .start(start), .busy(busy),
    .st(st)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  int cyc = 0;
  int pix [1024];
  bit wm [NW];
  int exp_q[$], due_q[$], got_q[$], model_q[$];
  int pcount = 0, fw_m = 1;
  int last_dout = 0;

  always @(posedge clk) cyc++;

  task automatic check(input string name, input int got, input int expv);
    checks++;
    if (got !== expv) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, got, expv, cyc);
    end
  endtask

  // Reference: acceptance-time bookkeeping plus a precomputed result list.
  always @(negedge clk) begin : compare
    int v;
    if (!rstn) begin
      due_q.delete();
      exp_q.delete();
      last_dout = 0;
    end else begin
      if (st.din_valid && st.din_ready) begin
        if ((pcount / fw_m) >= K - 1 && (pcount % fw_m) >= K - 1)
          due_q.push_back(cyc + 2);
        pcount++;
      end
      v = st.dout;
      if (st.ovalid) begin
        if (due_q.size() == 0 || exp_q.size() == 0) begin
          check("spurious_ovalid", 1, 0);
        end else begin
          check("ovalid_latency", cyc, due_q.pop_front());
          check("dout", v, exp_q.pop_front());
          check("done_with_last", int'(st.done), int'(exp_q.size() == 0));
          got_q.push_back(v);
        end
`ifdef BNN_CONV_BIN_OUT_EN
        check("bout", int'(st.bout), int'(v >= 0));
`endif
        last_dout = v;
      end else begin
        if (due_q.size() > 0 && due_q[0] <= cyc) begin
          check("missing_ovalid", 0, 1);
          void'(due_q.pop_front());
        end
        if (st.done) check("done_without_ovalid", 1, 0);
        check("dout_hold", v, last_dout);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_weights(input logic [NW-1:0] bits);
    weight_clr = 1'b1;
    weight_en  = 1'b1;
    weight     = 1'b1;
    tick();
    weight_clr = 1'b0;
    check("weight_full_after_clr", int'(weight_full), 0);
    for (int i = 0; i < NW; i++) begin
      weight = bits[i];
      wm[i]  = bits[i];
      tick();
    end
    weight = ~bits[0];
    tick();
    weight_en = 1'b0;
    check("weight_full_loaded", int'(weight_full), 1);
  endtask

  task automatic fill_image(input int w, input int h, input int mode);
    for (int i = 0; i < w * h; i++)
      pix[i] = (mode == 0) ? i + 1 : ((i * 37) % 201) - 100;
  endtask

  task automatic build_expected(input int w, input int h);
    int s, p;
    model_q.delete();
    for (int y = 0; y <= h - K; y++)
      for (int x = 0; x <= w - K; x++) begin
        s = 0;
        for (int i = 0; i < NW; i++) begin
          p = pix[(y + i / K) * w + x + i % K];
          s = wm[i] ? s + p : s - p;
        end
        model_q.push_back(s);
        exp_q.push_back(s);
      end
  endtask

  task automatic run_frame(input int w, input int h, input bit gaps,
                           input bit wdisturb, input int stop_after);
    int  p, budget, seen;
    bit  acc_now;
    fw_m = w;
    pcount = 0;
    got_q.delete();
    build_expected(w, h);
    img_w = DIM_W'(w);
    img_h = DIM_W'(h);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("busy_after_start", int'(busy), 1);
    p = 0;
    budget = 0;
    while (p < w * h && (stop_after == 0 || p < stop_after) && budget < 5000) begin
      st.din       = DW'(pix[p]);
      st.din_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
      if (wdisturb) begin
        weight_en  = 1'b1;
        weight     = 1'($urandom_range(0, 1));
        weight_clr = 1'($urandom_range(0, 1));
        start      = 1'b1;
      end
      acc_now = st.din_valid && st.din_ready;
      tick();
      if (acc_now) p++;
      budget++;
    end
    st.din_valid = 1'b0;
    weight_en = 1'b0;
    weight_clr = 1'b0;
    start = 1'b0;
    check("feed_within_budget", int'(budget < 5000), 1);
    if (stop_after == 0) begin
      seen = 0;
      for (int n = 0; n < 20 && seen == 0; n++) begin
        @(negedge clk);
        if (st.done) seen = 1;
      end
      check("done_seen", seen, 1);
      check("busy_at_done", int'(busy), 1);
      @(negedge clk);
      check("busy_after_done", int'(busy), 0);
      check("result_count", got_q.size(), (w - K + 1) * (h - K + 1));
      #1;
    end
  endtask

  task automatic check4(input string name, input int q[$], input int a0, input int a1,
                        input int a2, input int a3);
    int a [4];
    a[0] = a0; a[1] = a1; a[2] = a2; a[3] = a3;
    check({name, "_size"}, q.size(), 4);
    for (int i = 0; i < 4 && i < q.size(); i++) check(name, q[i], a[i]);
  endtask

  task automatic check_idle(input string name);
    check({name, "_busy"}, int'(busy), 0);
    check({name, "_din_ready"}, int'(st.din_ready), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    st.din = '0;
    st.din_valid = 1'b0;
    tick(); tick();
    @(negedge clk);
    check("rst_weight_full", int'(weight_full), 0);
    check("rst_din_ready", int'(st.din_ready), 0);
    check("rst_dout", int'(st.dout), 0);
    check("rst_ovalid", int'(st.ovalid), 0);
    check("rst_done", int'(st.done), 0);
    check("rst_busy", int'(busy), 0);
    rstn = 1'b1;
    tick();

    // All +1 weights, 4x4 ramp.
    fill_image(4, 4, 0);
    load_weights('1);
    run_frame(4, 4, 0, 0, 0);
    check4("model_all1", model_q, 54, 63, 90, 99);
    check4("dut_all1", got_q, 54, 63, 90, 99);

    // All -1 weights.
    load_weights('0);
    run_frame(4, 4, 0, 0, 0);
    check4("dut_all0", got_q, -54, -63, -90, -99);

    // Alternating weights, then clear and reload.
    load_weights(9'b1_0101_0101);
    run_frame(4, 4, 0, 0, 0);
    check("model_alt_first", model_q[0], 6);
    check("dut_alt_first", got_q[0], 6);
    load_weights('1);
    run_frame(4, 4, 0, 0, 0);
    check("dut_reload_first", got_q[0], 54);

    // Random valid gaps.
    run_frame(4, 4, 1, 0, 0);
    check4("dut_gaps", got_q, 54, 63, 90, 99);

    // Rejected starts.
    st.din_valid = 1'b1;
    img_w = 6'd2; img_h = 6'd4; start = 1'b1; tick(); start = 1'b0; tick();
    check_idle("start_w2");
    img_w = 6'd33; img_h = 6'd4; start = 1'b1; tick(); start = 1'b0; tick();
    check_idle("start_w33");
    img_w = 6'd4; img_h = 6'd2; start = 1'b1; tick(); start = 1'b0; tick();
    check_idle("start_h2");
    weight_clr = 1'b1; tick(); weight_clr = 1'b0;
    img_w = 6'd4; img_h = 6'd4; start = 1'b1; tick(); start = 1'b0; tick(); tick();
    check_idle("start_no_weights");
    st.din_valid = 1'b0;

    // Weight/start activity during RUN must be ignored.
    load_weights('1);
    run_frame(4, 4, 1, 1, 0);
    check4("dut_disturb", got_q, 54, 63, 90, 99);
    check("weight_full_kept", int'(weight_full), 1);

    // Reset after 7 pixels aborts the frame.
    run_frame(4, 4, 0, 0, 7);
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    @(negedge clk);
    check("abort_weight_full", int'(weight_full), 0);
    check("abort_busy", int'(busy), 0);
    check("abort_din_ready", int'(st.din_ready), 0);
    check("abort_ovalid", int'(st.ovalid), 0);
    check("abort_done", int'(st.done), 0);
    check("abort_dout", int'(st.dout), 0);
    repeat (4) @(negedge clk);
    #1;
    load_weights('1);
    run_frame(4, 4, 0, 0, 0);
    check4("dut_after_abort", got_q, 54, 63, 90, 99);

    // Signed pixels, non-square and full-width frames.
    fill_image(5, 3, 1);
    load_weights(9'b1_0101_0101);
    run_frame(5, 3, 1, 0, 0);
    fill_image(MAX_W, 3, 1);
    load_weights(9'b0_1101_0011);
    run_frame(MAX_W, 3, 0, 0, 0);

    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
